// File: rtl/decoder_2to4_fifo.sv
// decoder_2to4_fifo: buffers 2-bit codes from an upstream priority encoder
// in a circular FIFO and presents the head entry as a one-hot 4-bit word.
// Output dout/dout_valid are registered and are loaded with the decode of
// the next head entry, so they always track (count != 0) and the head code.
module decoder_2to4_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [1:0]               code,
  input  logic                     code_valid,
  output logic                     code_ready,
  output logic [3:0]               dout,
  output logic                     dout_valid,
  input  logic                     dout_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // One-hot decode of a 2-bit code; exactly one bit is set for any code.
  function automatic logic [3:0] onehot_decode(input logic [1:0] c);
    logic [3:0] d;
    case (c)
      2'd0:    d = 4'b0001;
      2'd1:    d = 4'b0010;
      2'd2:    d = 4'b0100;
      2'd3:    d = 4'b1000;
      default: d = 4'b0000;
    endcase
    return d;
  endfunction

  logic [1:0]       mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             overflow_r;
  logic [3:0]       dout_r;
  logic             dout_valid_r;

  logic             push_s;
  logic             pop_s;
  logic [PTR_W-1:0] nxt_wr_ptr_s;
  logic [PTR_W-1:0] nxt_rd_ptr_s;
  logic [CNT_W-1:0] nxt_count_s;
  logic [1:0]       nxt_head_s;
  logic [3:0]       nxt_dout_s;
  logic             nxt_dout_valid_s;

  // Ready depends only on the occupancy register, never on dout_ready.
  assign code_ready = (count_r != CNT_W'(DEPTH));
  assign push_s     = code_valid && code_ready;
  assign pop_s      = dout_valid_r && dout_ready;

  assign dout       = dout_r;
  assign dout_valid = dout_valid_r;
  assign count      = count_r;
  assign overflow   = overflow_r;

  // Next-state for pointers, occupancy and the registered head decode.
  always_comb begin
    nxt_wr_ptr_s     = wr_ptr_r;
    nxt_rd_ptr_s     = rd_ptr_r;
    nxt_count_s      = count_r;
    nxt_head_s       = 2'b00;
    nxt_dout_s       = 4'b0000;
    nxt_dout_valid_s = 1'b0;

    if (push_s) begin
      nxt_wr_ptr_s = wr_ptr_r + PTR_W'(1);
    end else begin
      nxt_wr_ptr_s = wr_ptr_r;
    end

    if (pop_s) begin
      nxt_rd_ptr_s = rd_ptr_r + PTR_W'(1);
    end else begin
      nxt_rd_ptr_s = rd_ptr_r;
    end

    case ({push_s, pop_s})
      2'b10:   nxt_count_s = count_r + CNT_W'(1);
      2'b01:   nxt_count_s = count_r - CNT_W'(1);
      default: nxt_count_s = count_r;
    endcase

    // The new head is the entry being written this edge when the read
    // pointer lands on the write slot (empty buffer or last entry popped).
    if (push_s && (nxt_rd_ptr_s == wr_ptr_r)) begin
      nxt_head_s = code;
    end else begin
      nxt_head_s = mem_r[nxt_rd_ptr_s];
    end

    if (nxt_count_s != CNT_W'(0)) begin
      nxt_dout_s       = onehot_decode(nxt_head_s);
      nxt_dout_valid_s = 1'b1;
    end else begin
      nxt_dout_s       = 4'b0000;
      nxt_dout_valid_s = 1'b0;
    end
  end

  // Control state and registered outputs; reset wins over push/pop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_r     <= {PTR_W{1'b0}};
      rd_ptr_r     <= {PTR_W{1'b0}};
      count_r      <= {CNT_W{1'b0}};
      overflow_r   <= 1'b0;
      dout_r       <= 4'b0000;
      dout_valid_r <= 1'b0;
    end else begin
      wr_ptr_r     <= nxt_wr_ptr_s;
      rd_ptr_r     <= nxt_rd_ptr_s;
      count_r      <= nxt_count_s;
      dout_r       <= nxt_dout_s;
      dout_valid_r <= nxt_dout_valid_s;
      if (code_valid && !code_ready) begin
        overflow_r <= 1'b1;
      end else begin
        overflow_r <= overflow_r;
      end
    end
  end

  // Entry storage; contents are left untouched by reset.
  always_ff @(posedge clk) begin
    if (rst_n && push_s) begin
      mem_r[wr_ptr_r] <= code;
    end
  end

endmodule

// File: tb/tb_decoder_2to4_fifo.sv
// Self-checking bench for decoder_2to4_fifo: a queue scoreboard holds the
// expected one-hot words; every cycle the outputs are compared against the
// queue state, and the head is popped/compared whenever it is consumed.
module tb_decoder_2to4_fifo;

  localparam int DEPTH = 4;

  logic                   clk;
  logic                   rst_n;
  logic [1:0]             code;
  logic                   code_valid;
  logic                   code_ready;
  logic [3:0]             dout;
  logic                   dout_valid;
  logic                   dout_ready;
  logic [$clog2(DEPTH):0] count;
  logic                   overflow;

  logic [3:0] exp_q [$];
  logic       exp_ovf;
  int         vec_cnt;
  int         err_cnt;

  decoder_2to4_fifo #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .code       (code),
    .code_valid (code_valid),
    .code_ready (code_ready),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .count      (count),
    .overflow   (overflow)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts and reports one check.
  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Check present outputs against the model, apply the model update for the
  // coming edge, then advance one clock and settle.
  task automatic step();
    logic [3:0] head;
    logic [3:0] popped;
    int         occ;
    occ  = exp_q.size();
    head = (occ != 0) ? exp_q[0] : 4'b0000;
    check_eq("count", 32'(count), 32'(occ));
    check_eq("code_ready", 32'(code_ready), 32'(occ != DEPTH));
    check_eq("dout_valid", 32'(dout_valid), 32'(occ != 0));
    check_eq("dout", 32'(dout), 32'(head));
    check_eq("overflow", 32'(overflow), 32'(exp_ovf));
    if (!rst_n) begin
      exp_q.delete();
      exp_ovf = 1'b0;
    end else begin
      if (code_valid && (occ == DEPTH)) exp_ovf = 1'b1;
      if ((occ != 0) && dout_ready) begin
        popped = exp_q.pop_front();
        check_eq("pop_order", 32'(dout), 32'(popped));
      end
      if (code_valid && (occ != DEPTH)) exp_q.push_back(4'b0001 << code);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_cnt    = 0;
    err_cnt    = 0;
    exp_ovf    = 1'b0;
    rst_n      = 1'b0;
    code       = 2'd0;
    code_valid = 1'b0;
    dout_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();  // reset state

    // Single code held on output while not consumed
    code = 2'd2; code_valid = 1'b1;
    step();
    code_valid = 1'b0;
    check_eq("lat_dout", 32'(dout), 32'(4'b0100));
    check_eq("lat_count", 32'(count), 32'd1);
    repeat (5) step();
    dout_ready = 1'b1;
    step();
    dout_ready = 1'b0;

    // Fill with 0..3, then overflow attempt while full
    for (int i = 0; i < 4; i++) begin
      code = 2'(i); code_valid = 1'b1;
      step();
    end
    code = 2'd1; code_valid = 1'b1;
    step();
    check_eq("full_count", 32'(count), 32'd4);
    check_eq("ovf_set", 32'(overflow), 32'd1);
    // Full with simultaneous offer and pop: pop only
    dout_ready = 1'b1;
    step();
    code_valid = 1'b0;
    repeat (5) step();
    check_eq("ovf_sticky", 32'(overflow), 32'd1);
    check_eq("drained", 32'(dout_valid), 32'd0);

    // Streaming at count=2, pointers wrap several times
    dout_ready = 1'b0;
    code_valid = 1'b1;
    code = 2'd3; step();
    code = 2'd1; step();
    dout_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      code = 2'(i % 4);
      step();
    end
    check_eq("stream_count", 32'(count), 32'd2);
    code_valid = 1'b0;
    repeat (3) step();

    // Reset with three buffered entries and active handshakes
    dout_ready = 1'b0;
    code_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      code = 2'(3 - i);
      step();
    end
    dout_ready = 1'b1;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    code_valid = 1'b0;
    check_eq("rst_count", 32'(count), 32'd0);
    check_eq("rst_dout", 32'(dout), 32'd0);
    check_eq("rst_ovf", 32'(overflow), 32'd0);
    check_eq("rst_ready", 32'(code_ready), 32'd1);
    step();

    // All 16 inputs of a 4-to-2 priority encoder (bit 3 highest priority)
    for (int p = 0; p < 16; p++) begin
      logic [3:0] pat;
      pat = 4'(p);
      code_valid = |pat;
      code = pat[3] ? 2'd3 : pat[2] ? 2'd2 : pat[1] ? 2'd1 : 2'd0;
      dout_ready = (p % 3) != 2;
      step();
    end
    code_valid = 1'b0;
    dout_ready = 1'b1;
    repeat (6) step();

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      code       = 2'($urandom_range(0, 3));
      code_valid = ($urandom_range(0, 99) < 60);
      dout_ready = ($urandom_range(0, 99) < 50);
      rst_n      = ($urandom_range(0, 99) != 0);
      step();
    end
    rst_n = 1'b1;
    code_valid = 1'b0;
    dout_ready = 1'b1;
    repeat (6) step();
    check_eq("final_empty", 32'(dout_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
